avalon_timer_host: RTL and testbench
====================================

Name: avalon_timer_host

Overview:
- Avalon-MM initiator that drives the 16-bit-data, 3-bit-address interval-timer slave used on the avalonBus.
- Programs the 32-bit period, enables and acknowledges the timer interrupt, and optionally snapshots the counter on each timeout.
- Presents a simple start/stop/tick interface to the flight-control logic, so the timer runs without a soft CPU.

Parameters:
- SNAP_EN, 1, 1 = run the snapshot sequence after each acknowledged timeout; 0 = skip it.
- MIN_PERIOD, 8, lower clamp applied to the latched period; covers the host's worst-case non-RUN window.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; latch period_in and begin programming
- stop  in  1  pulse; disable the timer and return to idle
- period_in  in  32  requested reload value
- address  out  3  Avalon address to the timer slave
- chipselect  out  1  Avalon chipselect
- write_n  out  1  Avalon write strobe, active low
- writedata  out  16  Avalon write data
- readdata  in  16  slave read data, registered in the slave (1-cycle read latency)
- irq  in  1  timer interrupt, level, held until the status register is written
- busy  out  1  high in any state other than IDLE
- tick  out  1  one-cycle pulse per acknowledged timeout
- tick_count  out  16  acknowledged timeouts since start; wraps FFFF -> 0000
- snapshot  out  32  last captured counter value
- snap_valid  out  1  one-cycle pulse when snapshot updates

Behaviour:
- Reset (and reset asserted in any state) forces:
  - state IDLE, chipselect 0, write_n 1, address 0, writedata 0
  - busy 0, tick 0, tick_count 0, snapshot 0, snap_valid 0, stop_pending 0
- Bus rules:
  - One access per cycle; the slave has no waitrequest.
  - A write is chipselect=1, write_n=0 for exactly one cycle.
  - A read is chipselect=1, write_n=1 for one cycle; readdata is sampled on the following cycle.
  - Idle bus is chipselect=0, write_n=1.
- Period latch: taken on an accepted start; P = max(period_in, MIN_PERIOD).
- States and transitions:
  - IDLE: start -> WR_PL; stop ignored.
  - WR_PL: write addr 2, data P[15:0] -> WR_PH.
  - WR_PH: write addr 3, data P[31:16] -> WR_CTL.
  - WR_CTL: write addr 1, data 0x0001 (interrupt enable) -> WR_CLR.
  - WR_CLR: write addr 0, data 0 (clear any stale timeout) -> RUN.
  - RUN, evaluated in priority order:
    - stop or stop_pending -> STP_CTL
    - else irq -> ACK
    - else stay in RUN
  - ACK: write addr 0; tick=1 this cycle; tick_count increments at the cycle's end. Next state SNAP_WR if SNAP_EN, else RUN.
  - SNAP_WR: write addr 4 (slave captures counter) -> SNAP_RDL.
  - SNAP_RDL: read addr 4 -> SNAP_RDH.
  - SNAP_RDH: read addr 5; snapshot[15:0] <= readdata -> SNAP_CAP.
  - SNAP_CAP: bus idle; snapshot[31:16] <= readdata; snap_valid=1 -> RUN.
  - STP_CTL: write addr 1, data 0 -> STP_CLR.
  - STP_CLR: write addr 0, data 0; clears stop_pending -> IDLE.
- Stop outside RUN/IDLE sets stop_pending; it is honoured on the next RUN entry, before any irq check.
- Start while busy is ignored; P is unchanged.
- Simultaneous start and stop in IDLE: start wins.
- irq sampled in RUN only. The slave drops irq on the edge that completes the ACK write, so there is no double count.
- Timeouts that occur while out of RUN are merged into the one level irq; at most one tick per acknowledge.
- tick_count is cleared on each accepted start.

Test Plan:
- Reset mid-sequence: assert reset while in SNAP_RDL -> next cycle chipselect 0, busy 0, tick_count 0, snapshot 0.
- Programming order: start, period_in=0x0001_86A0 -> writes on consecutive cycles: (2,0x86A0), (3,0x0001), (1,0x0001), (0,0x0000); busy high from the cycle after start.
- Periodic ticks with SNAP_EN=1 and the real timer slave, period 100 -> tick every 101 cycles; tick_count 1,2,3; snap_valid 4 cycles after each tick; snapshot equals the slave counter value at the SNAP_WR edge.
- Clamp: period_in=3 -> PERIOD_L write data 0x0008, PERIOD_H 0x0000.
- Stop handling:
  - Stop pulse during SNAP_RDH -> snapshot sequence completes, then writes (1,0x0000), (0,0x0000), then IDLE; no further ticks.
  - Stop in RUN -> same two writes starting the next cycle.
- Counter and start rules:
  - tick_count forced to 0xFFFF -> one more timeout gives 0x0000.
  - Start while busy -> no bus activity change, P unchanged.

Source files
------------

// File: rtl/avalon_timer_host.sv
// Avalon-MM initiator for the 16-bit interval-timer slave. It programs the
// 32-bit period, enables the timeout interrupt, acknowledges each timeout,
// and can optionally snapshot the running counter after every acknowledge.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        pulse: latch period_in and start programming the timer
//   stop         pulse: disable the timer and return to idle
//   period_in    requested 32-bit reload value
//   address, chipselect, write_n, writedata   Avalon master outputs
//   readdata     slave read data, valid the cycle after a read
//   irq          level interrupt from the slave, held until status is written
//   busy         high whenever the FSM is not idle
//   tick         one-cycle pulse per acknowledged timeout
//   tick_count   acknowledged timeouts since the last accepted start
//   snapshot     last captured 32-bit counter value
//   snap_valid   one-cycle pulse in the cycle the snapshot upper half lands
module avalon_timer_host #(
  parameter bit          SNAP_EN    = 1'b1,
  parameter int unsigned MIN_PERIOD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_in,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        irq,
  output logic        busy,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  localparam logic [31:0] MinPeriod = 32'(MIN_PERIOD);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StWrPl    = 4'd1;
  localparam logic [3:0] StWrPh    = 4'd2;
  localparam logic [3:0] StWrCtl   = 4'd3;
  localparam logic [3:0] StWrClr   = 4'd4;
  localparam logic [3:0] StRun     = 4'd5;
  localparam logic [3:0] StAck     = 4'd6;
  localparam logic [3:0] StSnapWr  = 4'd7;
  localparam logic [3:0] StSnapRdl = 4'd8;
  localparam logic [3:0] StSnapRdh = 4'd9;
  localparam logic [3:0] StSnapCap = 4'd10;
  localparam logic [3:0] StStpCtl  = 4'd11;
  localparam logic [3:0] StStpClr  = 4'd12;

  logic [3:0]  state_q, state_d;
  logic [31:0] period_q;
  logic        stop_pending_q;
  logic [15:0] tick_count_d;
  logic        start_ok;

  assign start_ok = (state_q == StIdle) && start;
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    address      = 3'd0;
    writedata    = 16'h0000;
    tick         = 1'b0;
    snap_valid   = 1'b0;
    tick_count_d = tick_count;
    case (state_q)
      StIdle: begin
        if (start) state_d = StWrPl;
      end
      StWrPl: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = period_q[15:0];
        state_d    = StWrPh;
      end
      StWrPh: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd3;
        writedata  = period_q[31:16];
        state_d    = StWrCtl;
      end
      StWrCtl: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 16'h0001;
        state_d    = StWrClr;
      end
      StWrClr: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        // A stop seen mid-sequence is honoured before any pending irq.
        if (stop || stop_pending_q) state_d = StStpCtl;
        else if (irq)               state_d = StAck;
      end
      StAck: begin
        chipselect   = 1'b1;
        write_n      = 1'b0;
        tick         = 1'b1;
        tick_count_d = tick_count + 16'd1;
        state_d      = SNAP_EN ? StSnapWr : StRun;
      end
      StSnapWr: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd4;
        state_d    = StSnapRdl;
      end
      StSnapRdl: begin
        chipselect = 1'b1;
        address    = 3'd4;
        state_d    = StSnapRdh;
      end
      StSnapRdh: begin
        chipselect = 1'b1;
        address    = 3'd5;
        state_d    = StSnapCap;
      end
      StSnapCap: begin
        snap_valid = 1'b1;
        state_d    = StRun;
      end
      StStpCtl: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        state_d    = StStpClr;
      end
      StStpClr: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (start_ok) tick_count_d = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      period_q       <= 32'h0;
      stop_pending_q <= 1'b0;
      tick_count     <= 16'h0000;
      snapshot       <= 32'h0;
    end else begin
      state_q    <= state_d;
      tick_count <= tick_count_d;
      if (start_ok) begin
        period_q <= (period_in < MinPeriod) ? MinPeriod : period_in;
      end
      // Read data lags the read by one cycle, so each half lands one state late.
      if (state_q == StSnapRdh) snapshot[15:0]  <= readdata;
      if (state_q == StSnapCap) snapshot[31:16] <= readdata;
      if (state_q == StStpClr) begin
        stop_pending_q <= 1'b0;
      end else if (stop && (state_q != StIdle) && (state_q != StRun)) begin
        stop_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_timer_host.sv
// Self-checking bench for avalon_timer_host with a behavioural interval-timer
// slave. Bus writes are scored against a queue of expected (addr, data, cycle)
// entries; snapshots are scored against a queue filled at each tick.
module tb_avalon_timer_host;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [31:0] period_in;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [15:0] writedata, readdata;
  logic        irq, busy, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snapshot;

  always #5 clk = ~clk;

  avalon_timer_host #(
    .SNAP_EN   (1'b1),
    .MIN_PERIOD(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .period_in (period_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .busy      (busy),
    .tick      (tick),
    .tick_count(tick_count),
    .snapshot  (snapshot),
    .snap_valid(snap_valid)
  );

  // Interval-timer slave: counts down from the period, flags a timeout and
  // reloads on reaching zero; status write clears the flag.
  logic [15:0] s_pl, s_ph, s_rd;
  logic [31:0] s_cnt, s_snap;
  logic        s_run, s_ito, s_to;
  wire         s_wr = chipselect && !write_n;

  assign irq      = s_to && s_ito;
  assign readdata = s_rd;

  always @(posedge clk) begin
    if (reset) begin
      s_pl <= 0; s_ph <= 0; s_rd <= 0; s_cnt <= 0; s_snap <= 0;
      s_run <= 0; s_ito <= 0; s_to <= 0;
    end else begin
      if (s_wr) begin
        case (address)
          3'd0: s_to <= 1'b0;
          3'd2: s_pl <= writedata;
          3'd3: s_ph <= writedata;
          3'd4: s_snap <= s_cnt;
          default: ;
        endcase
      end
      if (s_wr && address == 3'd1) begin
        s_ito <= writedata[0];
        s_run <= writedata[0];
        s_cnt <= {s_ph, s_pl};
      end else if (s_run) begin
        if (s_cnt == 0) begin
          s_cnt <= {s_ph, s_pl};
          s_to  <= 1'b1;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
      if (chipselect && write_n) begin
        s_rd <= (address == 3'd4) ? s_snap[15:0] :
                (address == 3'd5) ? s_snap[31:16] : {15'b0, s_to};
      end
    end
  end

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [31:0] period;
    logic [15:0] pl;
    logic [15:0] ph;
  } prog_vec_t;

  wr_t         wr_q[$];
  logic [31:0] snap_q[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  int          n_ticks = 0, last_tick = 0, exp_tc = 0;
  bit          have_tick = 0, snap_pend = 0, wr_chk = 0, tc_track = 1;
  logic [31:0] cur_p = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h, expected none (cycle %0d)", name, act, cyc);
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wr_q.push_back(e);
  endtask

  // Sampled mid-cycle: scores bus writes, ticks and snapshots.
  task automatic monitor();
    wr_t e;
    if (reset) begin
      exp_tc = 0; snap_q.delete(); have_tick = 0; snap_pend = 0;
      return;
    end
    if (start && !busy) begin
      exp_tc = 0; have_tick = 0;
      cur_p = (period_in < 32'd8) ? 32'd8 : period_in;
    end
    if (chipselect && !write_n && wr_chk) begin
      if (wr_q.size() == 0) begin
        fail_now("unexpected_write", {13'b0, address, writedata});
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", {29'b0, address}, {29'b0, e.addr});
        check("wr_data", {16'b0, writedata}, {16'b0, e.data});
        check("wr_cycle", cyc, e.cyc);
      end
    end
    if (snap_pend) begin
      snap_pend = 0;
      if (snap_q.size() == 0) fail_now("snapshot_unexpected", snapshot);
      else check("snapshot_value", snapshot, snap_q.pop_front());
    end
    if (tick) begin
      if (tc_track) check("tick_count_at_tick", {16'b0, tick_count}, exp_tc);
      if (have_tick) check("tick_gap", cyc - last_tick, cur_p + 1);
      last_tick = cyc; have_tick = 1; exp_tc++; n_ticks++;
      // Counter sits two below the reload value when SNAP_WR completes.
      snap_q.push_back(cur_p - 32'd2);
    end
    if (snap_valid) begin
      check("snap_valid_delay", cyc - last_tick, 4);
      snap_pend = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic [31:0] p, input logic [15:0] pl, input logic [15:0] ph,
                          input bit with_stop);
    int s;
    s = cyc;
    wr_chk = 1;
    period_in = p; start = 1; stop = with_stop;
    push_wr(3'd2, pl, s + 1);
    push_wr(3'd3, ph, s + 2);
    push_wr(3'd1, 16'h0001, s + 3);
    push_wr(3'd0, 16'h0000, s + 4);
    step();
    start = 0; stop = 0;
    check("busy_after_start", {31'b0, busy}, 1);
    repeat (4) step();
    check("prog_writes_drained", wr_q.size(), 0);
  endtask

  task automatic do_stop_run();
    int s;
    s = cyc;
    wr_chk = 1;
    stop = 1;
    push_wr(3'd1, 16'h0000, s + 1);
    push_wr(3'd0, 16'h0000, s + 2);
    step();
    stop = 0;
    repeat (2) step();
    check("busy_after_stop", {31'b0, busy}, 0);
    check("stop_writes_drained", wr_q.size(), 0);
  endtask

  task automatic wait_tick(input int budget, input string name);
    int t0, k;
    t0 = n_ticks; k = 0;
    while (n_ticks == t0 && k < budget) begin
      step();
      k++;
    end
    if (n_ticks == t0) fail_now(name, k);
  endtask

  initial begin
    prog_vec_t vecs[6];
    int        nt;

    vecs[0] = '{32'h0001_86A0, 16'h86A0, 16'h0001};
    vecs[1] = '{32'h0000_0003, 16'h0008, 16'h0000};
    vecs[2] = '{32'h0000_0000, 16'h0008, 16'h0000};
    vecs[3] = '{32'h0000_0008, 16'h0008, 16'h0000};
    vecs[4] = '{32'h0000_0009, 16'h0009, 16'h0000};
    vecs[5] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF};

    reset = 1; start = 0; stop = 0; period_in = 0;
    repeat (3) step();
    check("rst_chipselect", {31'b0, chipselect}, 0);
    check("rst_write_n", {31'b0, write_n}, 1);
    check("rst_address", {29'b0, address}, 0);
    check("rst_writedata", {16'b0, writedata}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_tick", {31'b0, tick}, 0);
    check("rst_tick_count", {16'b0, tick_count}, 0);
    check("rst_snapshot", snapshot, 0);
    check("rst_snap_valid", {31'b0, snap_valid}, 0);
    reset = 0;
    step();

    // Programming order and period clamp, each followed by a stop in RUN.
    foreach (vecs[i]) begin
      do_start(vecs[i].period, vecs[i].pl, vecs[i].ph, 1'b0);
      do_stop_run();
      step();
    end

    // Start and stop together in IDLE: start wins, no stop sequence follows.
    do_start(32'd1000, 16'd1000, 16'd0, 1'b1);
    repeat (10) step();
    check("start_wins_busy", {31'b0, busy}, 1);
    do_stop_run();
    step();

    // Periodic ticks with snapshots, period 100.
    do_start(32'd100, 16'd100, 16'd0, 1'b0);
    wr_chk = 0;
    repeat (3) wait_tick(400, "tick_timeout");
    check("tick_count_after_3", {16'b0, tick_count}, 3);

    // Start while busy: ignored, no bus activity, count kept.
    repeat (20) step();
    wr_chk = 1;
    period_in = 32'd5; start = 1;
    step();
    start = 0;
    check("busy_start_busy", {31'b0, busy}, 1);
    check("busy_start_cs", {31'b0, chipselect}, 0);
    check("busy_start_count", {16'b0, tick_count}, 3);
    repeat (3) step();
    wr_chk = 0;

    // Stop during SNAP_RDH: snapshot finishes, then the stop writes.
    wait_tick(400, "tick_timeout_rdh");
    repeat (2) step();
    stop = 1;
    wr_chk = 1;
    push_wr(3'd1, 16'h0000, cyc + 3);
    push_wr(3'd0, 16'h0000, cyc + 4);
    step();
    stop = 0;
    repeat (4) step();
    check("rdh_stop_busy", {31'b0, busy}, 0);
    check("rdh_stop_drained", wr_q.size(), 0);
    nt = n_ticks;
    repeat (250) step();
    check("no_ticks_after_stop", n_ticks, nt);
    check("idle_after_stop", {31'b0, busy}, 0);

    // tick_count wrap FFFF -> 0000.
    do_start(32'd30, 16'd30, 16'd0, 1'b0);
    wr_chk = 0;
    wait_tick(200, "tick_timeout_wrap");
    repeat (8) step();
    tc_track = 0;
    force dut.tick_count_d = 16'hFFFF;
    step();
    release dut.tick_count_d;
    check("forced_count", {16'b0, tick_count}, 32'h0000_FFFF);
    wait_tick(200, "tick_timeout_wrap2");
    check("count_wrapped", {16'b0, tick_count}, 0);
    repeat (4) step();
    do_stop_run();
    tc_track = 1;
    step();

    // Reset asserted while in SNAP_RDL.
    do_start(32'd20, 16'd20, 16'd0, 1'b0);
    wr_chk = 0;
    wait_tick(200, "tick_timeout_reset");
    step();
    reset = 1;
    step();
    check("midrst_chipselect", {31'b0, chipselect}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_tick_count", {16'b0, tick_count}, 0);
    check("midrst_snapshot", snapshot, 0);
    check("midrst_snap_valid", {31'b0, snap_valid}, 0);
    reset = 0;
    repeat (3) step();
    check("snap_queue_drained", snap_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
